mem_port_arb: RTL and testbench
===============================

Name: mem_port_arb

Overview:
- Arbiter that shares one single-port instruction/data memory between the IF stage (read-only fetch) and the MEM stage (load/store).
- Grants one access at a time and sequences the memory's fixed read latency.
- Returns per-port ready pulses and derives the IF/MEM stall signals that drive the pipeline-register write enables.
- Sits between the pipeline top and a unified memory model that replaces the separate instruction and data memories.

Parameters:
ADDR_W, 10, word-address width (memory word index, byte address [ADDR_W+1:2])
DATA_W, 32, data width
MEM_LAT, 1, cycles from the mem_en cycle to valid mem_rdata; legal range 1..7
STARVE_MAX, 4, consecutive data grants allowed while a fetch waits before the fetch is forced through; legal range 1..15

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
if_req  in  1  fetch request; held with if_addr until if_ready
if_addr  in  ADDR_W  fetch word address
if_rdata  out  DATA_W  fetched instruction; valid in the if_ready cycle, held until the next fetch completes
if_ready  out  1  one-cycle completion pulse for the fetch
dm_req  in  1  data request; held with dm_we/dm_addr/dm_wdata until dm_ready
dm_we  in  1  1=store, 0=load
dm_addr  in  ADDR_W  data word address
dm_wdata  in  DATA_W  store data
dm_rdata  out  DATA_W  load data; valid in the dm_ready cycle, held until the next load completes
dm_ready  out  1  one-cycle completion pulse for the data access
mem_en  out  1  memory access strobe, high for exactly one cycle per access
mem_we  out  1  memory write enable, qualified by mem_en
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after the mem_en cycle
stall_if  out  1  if_req & ~if_ready
stall_mem  out  1  dm_req & ~dm_ready

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, cnt=0, starve=0, if_rdata=0, dm_rdata=0, and all strobes (mem_en, mem_we, if_ready, dm_ready) are 0.
- mem_addr and mem_wdata return 0 when idle.
- States:
  - IDLE: no access in flight.
  - BUSY_I: fetch in flight.
  - BUSY_D: data access in flight.
- IDLE transitions:
  - dm_req only -> BUSY_D.
  - if_req only -> BUSY_I.
  - Both requests, starve<STARVE_MAX -> BUSY_D and starve++.
  - Both requests, starve==STARVE_MAX -> BUSY_I.
  - Any BUSY_I grant clears starve.
  - dm_req alone does not change starve.
- On a grant, the chosen port is latched and cnt<=0.
- BUSY_x, cycle cnt==0:
  - mem_en=1.
  - mem_addr/mem_we/mem_wdata are muxed from the latched port; mem_we=dm_we in BUSY_D and 0 in BUSY_I.
- BUSY_x, all cycles: cnt increments every cycle.
- BUSY_x, when cnt==MEM_LAT:
  - x_ready=1.
  - For reads, x_rdata is taken combinationally from mem_rdata and registered for hold.
  - Next state is IDLE.
- Stores: dm_ready follows the same timing; dm_rdata keeps its previous value.
- Latency: request seen in IDLE at T0 -> mem_en at T1 -> ready at T1+MEM_LAT. Issue period is MEM_LAT+2 cycles per access.
- Requester drops or changes its req in the cycle after ready. A req still high in IDLE is treated as a new request.
- Request deasserted mid-access: the access completes, ready still pulses, and the store is still performed.
- No simultaneous grant is possible: only one access is in flight at a time. The request that loses stays pending, and its stall stays high.
- stall_if and stall_mem are purely combinational from req/ready, so the pipeline registers advance in the ready cycle.
- Reset asserted mid-access aborts immediately with no ready pulse. After deassertion the arbiter is in IDLE.
- cnt width is 3 bits and starve width is 4 bits. Neither wraps: cnt is cleared on every grant, and starve saturates at STARVE_MAX.

Decomposition:
- Shared package `mem_arb_def.v`:
  - State localparams ARB_IDLE=2'b00, ARB_BUSY_I=2'b01, ARB_BUSY_D=2'b10.
  - Port-select encoding.
  - Default MEM_LAT and STARVE_MAX.
- One natural sub-module, `arb_starve_cnt`: a saturating counter with inc, clr, and a sat output.
- Everything else is flat in `mem_port_arb`.

Test Plan:
- Reset: rst=0 at t=5 while both reqs are high -> all outputs 0 and state IDLE; after rst=1 the first grant is BUSY_D.
- Lone fetch, MEM_LAT=1: if_req=1, if_addr=10'h004, mem_rdata=32'h20080005 -> mem_en at T1 with mem_addr=4, if_ready and if_rdata=32'h20080005 at T2, stall_if=1 at T0..T1 and 0 at T2.
- Store then load, same address: dm_we=1, dm_addr=10'h010, wdata=32'hDEADBEEF -> mem_we=1 at mem_en. The following load -> dm_rdata=32'hDEADBEEF; dm_rdata unchanged during the store's ready.
- Contention, STARVE_MAX=4: both reqs held continuously, requesters reasserting after ready -> grant order D,D,D,D,I,D,D,D,D,I; if_ready every 5th completion.
- MEM_LAT=3: lone load -> ready exactly 4 cycles after the request is sampled; next mem_en no earlier than 5 cycles after the previous one.
- Reset mid-access: rst=0 in BUSY_D at cnt==0 -> no dm_ready, mem_en=0 immediately; after release the pending if_req is granted first.

Source files
------------

// File: rtl/mem_port_arb_pkg.sv
// Shared definitions for the IF/MEM single-port memory arbiter:
// state and port-select encodings plus default timing parameters.
package mem_port_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'b00,
    ARB_BUSY_I = 2'b01,
    ARB_BUSY_D = 2'b10
  } arb_state_t;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_DM = 1'b1
  } port_sel_t;

  localparam int DEF_MEM_LAT    = 1;
  localparam int DEF_STARVE_MAX = 4;
  localparam int CNT_W          = 3;
  localparam int STARVE_W       = 4;

  // The busy state already records which port owns the memory.
  function automatic port_sel_t state_port(input arb_state_t s);
    return (s == ARB_BUSY_D) ? PORT_DM : PORT_IF;
  endfunction

endpackage

// File: rtl/mem_port_arb_starve_cnt.sv
// Saturating counter of consecutive data grants taken while a fetch waits.
module arb_starve_cnt #(
  parameter int W   = 4,
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam logic [W-1:0] MAX_C = W'(MAX);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != MAX_C)) begin
      cnt <= cnt + W'(1);
    end
  end

  assign sat = (cnt == MAX_C);

endmodule

// File: rtl/mem_port_arb.sv
// Shares one single-port memory between instruction fetch and load/store,
// sequencing the fixed read latency and producing ready pulses and stalls.
module mem_port_arb
  import mem_port_arb_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = DEF_MEM_LAT,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_mem
);

  localparam logic [CNT_W-1:0] LAT_C = CNT_W'(MEM_LAT);

  arb_state_t        state;
  logic [CNT_W-1:0]  cnt;
  logic              lat_we;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] dm_rdata_q;

  logic      idle;
  logic      done;
  logic      starve_sat;
  logic      starve_inc;
  logic      grant_i;
  logic      grant_d;
  port_sel_t sel;

  assign idle = (state == ARB_IDLE);
  assign sel  = state_port(state);
  assign done = !idle && (cnt == LAT_C);

  // Data wins contention until the waiting fetch has been passed over STARVE_MAX times.
  always_comb begin
    grant_d    = 1'b0;
    grant_i    = 1'b0;
    starve_inc = 1'b0;
    if (idle) begin
      if (dm_req && (!if_req || !starve_sat)) begin
        grant_d    = 1'b1;
        starve_inc = if_req;
      end else if (if_req) begin
        grant_i = 1'b1;
      end
    end
  end

  arb_starve_cnt #(
    .W   (STARVE_W),
    .MAX (STARVE_MAX)
  ) u_starve (
    .clk (clk),
    .rst (rst),
    .inc (starve_inc),
    .clr (grant_i),
    .sat (starve_sat)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ARB_IDLE;
      cnt        <= '0;
      lat_we     <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      unique case (state)
        ARB_IDLE: begin
          cnt <= '0;
          if (grant_d) begin
            state  <= ARB_BUSY_D;
            lat_we <= dm_we;
          end else if (grant_i) begin
            state  <= ARB_BUSY_I;
            lat_we <= 1'b0;
          end
        end
        ARB_BUSY_I, ARB_BUSY_D: begin
          if (done) begin
            state <= ARB_IDLE;
            cnt   <= '0;
            if (sel == PORT_IF) begin
              if_rdata_q <= mem_rdata;
            end else if (!lat_we) begin
              dm_rdata_q <= mem_rdata;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= ARB_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Memory side is driven from the owning port; everything reads as zero when idle.
  always_comb begin
    mem_en    = !idle && (cnt == '0);
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      ARB_BUSY_I: begin
        mem_addr = if_addr;
      end
      ARB_BUSY_D: begin
        mem_addr  = dm_addr;
        mem_wdata = dm_wdata;
        mem_we    = mem_en && dm_we;
      end
      default: begin
        mem_addr = '0;
      end
    endcase
  end

  always_comb begin
    if_ready  = done && (sel == PORT_IF);
    dm_ready  = done && (sel == PORT_DM);
    if_rdata  = if_ready ? mem_rdata : if_rdata_q;
    dm_rdata  = (dm_ready && !lat_we) ? mem_rdata : dm_rdata_q;
    stall_if  = if_req && !if_ready;
    stall_mem = dm_req && !dm_ready;
  end

endmodule

// File: tb/tb_mem_port_arb.sv
// Bench for mem_port_arb: transaction-level reference model with per-cycle
// comparison, directed scenarios, randomized traffic and a MEM_LAT=3 instance.
module tb_mem_port_arb;

  localparam int AW   = 10;
  localparam int DW   = 32;
  localparam int LAT  = 1;
  localparam int SMAX = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b1;

  logic          if_req, dm_req, dm_we;
  logic [AW-1:0] if_addr, dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [DW-1:0] if_rdata, dm_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  logic          if_ready, dm_ready, mem_en, mem_we, stall_if, stall_mem;

  mem_port_arb #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) u_dut (
    .clk(clk), .rst(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_mem(stall_mem)
  );

  // Second instance with a 3-cycle memory for latency/issue-period checks.
  logic          b_if_req, b_dm_req, b_dm_we;
  logic [AW-1:0] b_if_addr, b_dm_addr;
  logic [DW-1:0] b_dm_wdata;
  logic [DW-1:0] b_if_rdata, b_dm_rdata, b_mem_wdata;
  logic [DW-1:0] b_mem_rdata;
  logic [AW-1:0] b_mem_addr;
  logic          b_if_ready, b_dm_ready, b_mem_en, b_mem_we, b_stall_if, b_stall_mem;

  mem_port_arb #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(3), .STARVE_MAX(SMAX)) u_dut3 (
    .clk(clk), .rst(rst_n),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata), .if_ready(b_if_ready),
    .dm_req(b_dm_req), .dm_we(b_dm_we), .dm_addr(b_dm_addr), .dm_wdata(b_dm_wdata),
    .dm_rdata(b_dm_rdata), .dm_ready(b_dm_ready),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .stall_if(b_stall_if), .stall_mem(b_stall_mem)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0b required=%0b at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chkw(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h at t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] init_val(input int a);
    if (a == 4) return 32'h2008_0005;
    return 32'h1357_0000 ^ (32'(a) * 32'h0000_0101);
  endfunction

  // Unified memory device: one access per mem_en, data back LAT(=1) cycle later.
  logic [DW-1:0] dev_mem [0:1023];
  bit            dev_wr  [0:1023];
  logic [DW-1:0] rd_q, garb;
  bit            rd_vld;

  always @(posedge clk) begin
    garb   <= $urandom;
    rd_vld <= mem_en;
    if (mem_en) begin
      rd_q <= dev_wr[mem_addr] ? dev_mem[mem_addr] : init_val(int'(mem_addr));
      if (mem_we) begin
        dev_mem[mem_addr] <= mem_wdata;
        dev_wr[mem_addr]  <= 1'b1;
      end
    end
  end
  assign mem_rdata = rd_vld ? rd_q : garb;

  // Reference model: one transaction at a time, tracked by the cycle numbers
  // at which its strobe and its completion are due.
  int            cyc = 0;
  bit            started = 1'b0;
  bit            m_busy, m_dport, m_we;
  int            m_en_cyc, m_rdy_cyc, m_starve;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] e_if_rd, e_dm_rd;
  bit            e_en, e_ir, e_dr;
  logic [DW-1:0] ref_mem [0:1023];
  bit            ref_wr  [0:1023];

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_wr[a] ? ref_mem[a] : init_val(int'(a));
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_busy   = 1'b0;
      m_starve = 0;
      e_if_rd  = '0;
      e_dm_rd  = '0;
      if (started) begin
        chk1("rst_mem_en", mem_en, 1'b0);
        chk1("rst_if_ready", if_ready, 1'b0);
        chk1("rst_dm_ready", dm_ready, 1'b0);
        chkw("rst_if_rdata", if_rdata, 32'h0);
        chkw("rst_dm_rdata", dm_rdata, 32'h0);
      end
    end else if (started) begin
      e_en = m_busy && (cyc == m_en_cyc);
      e_ir = m_busy && !m_dport && (cyc == m_rdy_cyc);
      e_dr = m_busy && m_dport && (cyc == m_rdy_cyc);
      if (e_ir) e_if_rd = ref_rd(m_addr);
      if (e_dr && !m_we) e_dm_rd = ref_rd(m_addr);
      if (e_en && m_we) begin
        ref_mem[m_addr] = m_wdata;
        ref_wr[m_addr]  = 1'b1;
      end
      chk1("mdl_mem_en", mem_en, e_en);
      chk1("mdl_if_ready", if_ready, e_ir);
      chk1("mdl_dm_ready", dm_ready, e_dr);
      chkw("mdl_if_rdata", if_rdata, e_if_rd);
      chkw("mdl_dm_rdata", dm_rdata, e_dm_rd);
      chk1("mdl_stall_if", stall_if, if_req && !e_ir);
      chk1("mdl_stall_mem", stall_mem, dm_req && !e_dr);
      if (e_en) begin
        chkw("mdl_mem_addr", 32'(mem_addr), 32'(m_addr));
        chk1("mdl_mem_we", mem_we, m_we);
        if (m_we) chkw("mdl_mem_wdata", mem_wdata, m_wdata);
      end
      if (!m_busy) begin
        chkw("mdl_idle_addr", 32'(mem_addr), 32'h0);
        chkw("mdl_idle_wdata", mem_wdata, 32'h0);
      end
      if (m_busy) begin
        if (cyc == m_rdy_cyc) m_busy = 1'b0;
      end else if (if_req || dm_req) begin
        if (dm_req && (!if_req || m_starve < SMAX)) begin
          m_dport = 1'b1;
          if (if_req) m_starve++;
          m_addr  = dm_addr;
          m_we    = dm_we;
          m_wdata = dm_wdata;
        end else begin
          m_dport  = 1'b0;
          m_starve = 0;
          m_addr   = if_addr;
          m_we     = 1'b0;
          m_wdata  = '0;
        end
        m_busy    = 1'b1;
        m_en_cyc  = cyc + 1;
        m_rdy_cyc = cyc + 1 + LAT;
      end
    end
  end

  task automatic go_idle();
    @(posedge clk); #1;
    if_req = 1'b0;
    dm_req = 1'b0;
    dm_we  = 1'b0;
    repeat (12) @(posedge clk);
    #1;
  endtask

  task automatic wait_first_ready(input string nm, input logic want_dm);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (if_ready || dm_ready) begin
        seen = 1'b1;
        chk1({nm, "_dm"}, dm_ready, want_dm);
        chk1({nm, "_if"}, if_ready, !want_dm);
      end
    end
    if (!seen) chk1({nm, "_timeout"}, 1'b0, 1'b1);
  endtask

  logic [DW-1:0] prev_dm;
  bit            exp_ord [0:9];
  int            n_done;
  bit            ir_seen, dr_seen;
  int            k_en1, k_en2, k_r, n_en;
  logic [DW-1:0] b_rd;

  initial begin
    if_req = 1'b1; dm_req = 1'b1; dm_we = 1'b0;
    if_addr = 10'd8; dm_addr = 10'd20; dm_wdata = '0;
    b_if_req = 1'b0; b_dm_req = 1'b0; b_dm_we = 1'b0;
    b_if_addr = '0; b_dm_addr = 10'd5; b_dm_wdata = '0;
    b_mem_rdata = 32'hCAFE_0123;
    exp_ord = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    // Reset with both requests pending.
    #5 rst_n = 1'b0;
    #1;
    started = 1'b1;
    chk1("reset_mem_en", mem_en, 1'b0);
    chk1("reset_mem_we", mem_we, 1'b0);
    chk1("reset_if_ready", if_ready, 1'b0);
    chk1("reset_dm_ready", dm_ready, 1'b0);
    chkw("reset_if_rdata", if_rdata, 32'h0);
    chkw("reset_dm_rdata", dm_rdata, 32'h0);
    chkw("reset_mem_addr", 32'(mem_addr), 32'h0);
    chkw("reset_mem_wdata", mem_wdata, 32'h0);
    chk1("reset_stall_if", stall_if, 1'b1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_first_ready("first_grant", 1'b1);
    go_idle();

    // Lone fetch of word 4.
    if_req = 1'b1; if_addr = 10'h004;
    @(negedge clk);
    chk1("fetch_t0_stall", stall_if, 1'b1);
    chk1("fetch_t0_mem_en", mem_en, 1'b0);
    @(negedge clk);
    chk1("fetch_t1_mem_en", mem_en, 1'b1);
    chkw("fetch_t1_addr", 32'(mem_addr), 32'h4);
    chk1("fetch_t1_stall", stall_if, 1'b1);
    @(negedge clk);
    chk1("fetch_t2_ready", if_ready, 1'b1);
    chkw("fetch_t2_rdata", if_rdata, 32'h2008_0005);
    chk1("fetch_t2_stall", stall_if, 1'b0);
    go_idle();

    // Store then load of the same word.
    prev_dm = dm_rdata;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 10'h010; dm_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    @(negedge clk);
    chk1("store_mem_en", mem_en, 1'b1);
    chk1("store_mem_we", mem_we, 1'b1);
    chkw("store_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    chkw("store_mem_addr", 32'(mem_addr), 32'h10);
    @(negedge clk);
    chk1("store_ready", dm_ready, 1'b1);
    chkw("store_rdata_held", dm_rdata, prev_dm);
    @(posedge clk); #1;
    dm_we = 1'b0; dm_wdata = '0;
    @(negedge clk);
    @(negedge clk);
    chk1("load_mem_en", mem_en, 1'b1);
    chk1("load_mem_we", mem_we, 1'b0);
    @(negedge clk);
    chk1("load_ready", dm_ready, 1'b1);
    chkw("load_rdata", dm_rdata, 32'hDEAD_BEEF);
    go_idle();

    // Continuous contention: four data grants, then the fetch is forced through.
    if_req = 1'b1; if_addr = 10'd8; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'd12;
    n_done = 0;
    for (int i = 0; i < 120 && n_done < 10; i++) begin
      @(negedge clk);
      if (if_ready || dm_ready) begin
        chk1($sformatf("contention_grant_%0d", n_done), dm_ready, exp_ord[n_done]);
        n_done++;
      end
    end
    if (n_done < 10) chk1("contention_timeout", 1'b0, 1'b1);
    go_idle();

    // Reset in the strobe cycle of a data access, with a fetch waiting.
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'd30;
    @(posedge clk); #1;
    chk1("pre_abort_mem_en", mem_en, 1'b1);
    rst_n = 1'b0; dm_req = 1'b0; if_req = 1'b1; if_addr = 10'd4;
    #1;
    chk1("abort_mem_en", mem_en, 1'b0);
    chk1("abort_dm_ready", dm_ready, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_first_ready("post_abort_grant", 1'b0);
    go_idle();

    // Randomized traffic obeying the hold-until-ready protocol.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      ir_seen = if_ready;
      dr_seen = dm_ready;
      @(posedge clk); #1;
      if (!if_req || ir_seen) begin
        if_req  = ($urandom_range(0, 3) != 0);
        if_addr = AW'($urandom_range(0, 63));
      end
      if (!dm_req || dr_seen) begin
        dm_req   = ($urandom_range(0, 3) != 0);
        dm_we    = 1'($urandom_range(0, 1));
        dm_addr  = AW'($urandom_range(0, 63));
        dm_wdata = $urandom;
      end
    end
    go_idle();

    // MEM_LAT=3 instance: load latency and issue period.
    b_dm_req = 1'b1;
    k_en1 = -1; k_en2 = -1; k_r = -1; n_en = 0; b_rd = '0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (b_mem_en) begin
        if (k <= 5) n_en++;
        if (k_en1 < 0) k_en1 = k;
        else if (k_en2 < 0) k_en2 = k;
      end
      if (b_dm_ready && k_r < 0) begin
        k_r  = k;
        b_rd = b_dm_rdata;
        chk1("lat3_stall_at_ready", b_stall_mem, 1'b0);
      end
    end
    @(posedge clk); #1;
    b_dm_req = 1'b0;
    chkw("lat3_first_en", 32'(k_en1), 32'd1);
    chkw("lat3_ready_delay", 32'(k_r), 32'd4);
    chkw("lat3_issue_period", 32'(k_en2 - k_en1), 32'd5);
    chkw("lat3_en_pulses", 32'(n_en), 32'd1);
    chkw("lat3_dm_rdata", b_rd, 32'hCAFE_0123);
    repeat (10) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
